// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the processor top
// that places the loader in front of the core.
package imem_loader_pkg;

  localparam int IMEM_DEPTH_DEFAULT = 64;
  localparam int HDR_BYTES          = 2;
  localparam int BYTES_PER_WORD     = 4;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in
// bits 7:0, the last in the top byte. The completed word is presented
// combinationally on the strobe of its last byte, so the owner can register
// it on the same edge that accepts that byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_byte_stb,
  input  logic [7:0]  i_byte,
  input  logic        i_clear,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam int                 IDX_W    = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]                    r_byte_idx;
  logic [8*(BYTES_PER_WORD-1)-1:0]     r_partial;
  logic                                w_last_byte;

  assign w_last_byte  = i_byte_stb && !i_clear && (r_byte_idx == LAST_IDX);
  assign o_word_valid = w_last_byte;
  assign o_word       = {i_byte, r_partial};

  // Shift earlier bytes down from the top so the oldest ends up in bits 7:0;
  // the byte index only moves on a strobe, so upstream gaps just stall here.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_byte_idx <= '0;
      r_partial  <= '0;
    end else if (i_byte_stb) begin
      if (r_byte_idx == LAST_IDX) begin
        r_byte_idx <= '0;
      end else begin
        r_partial  <= {i_byte, r_partial[8*(BYTES_PER_WORD-1)-1:8]};
        r_byte_idx <= r_byte_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a byte stream (16-bit word count, then little-endian
// 32-bit words), writes the words into instruction memory and then releases
// the core from reset.
//
// state | meaning
// HDR   | collecting the two-byte word count
// LOAD  | assembling words and writing them to imem
// RUN   | program loaded, core out of reset
// ERR   | word count too large for imem, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  input  logic              i_restart,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_reset,
  output logic              o_load_done,
  output logic              o_load_err
);

  localparam logic [15:0] DEPTH16 = 16'(IMEM_DEPTH);

  loader_state_e     r_state;
  loader_state_e     w_state_nxt;

  logic              r_hdr_idx;
  logic [7:0]        r_hdr_lo;
  logic [15:0]       r_count;
  // One bit wider than the address so a full-depth load never wraps to 0.
  logic [ADDR_W:0]   r_word_idx;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;

  logic              w_rx_ready;
  logic              w_xfer;
  logic              w_hdr_last;
  logic [15:0]       w_hdr_n;
  logic              w_words_done;
  logic              w_asm_stb;
  logic              w_asm_clear;
  logic [31:0]       w_word;
  logic              w_word_valid;

  assign w_rx_ready   = (r_state == HDR) || (r_state == LOAD);
  assign w_xfer       = i_rx_valid && w_rx_ready;
  assign w_hdr_last   = (r_hdr_idx == 1'(HDR_BYTES - 1));
  assign w_hdr_n      = {i_rx_data, r_hdr_lo};
  assign w_words_done = r_imem_we &&
                        ({{(15 - ADDR_W){1'b0}}, r_word_idx} == r_count);
  assign w_asm_stb    = w_xfer && (r_state == LOAD);
  assign w_asm_clear  = (r_state != LOAD);

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_byte_stb   (w_asm_stb),
    .i_byte       (i_rx_data),
    .i_clear      (w_asm_clear),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived status outputs.
  always_comb begin
    w_state_nxt  = r_state;
    o_core_reset = 1'b1;
    o_load_done  = 1'b0;
    o_load_err   = 1'b0;
    case (r_state)
      HDR: begin
        if (w_xfer && w_hdr_last) begin
          if (w_hdr_n == 16'd0) begin
            w_state_nxt = RUN;
          end else if (w_hdr_n > DEPTH16) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        // Leave only once the last word's write pulse has been on the port.
        if (w_words_done) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        o_core_reset = 1'b0;
        o_load_done  = 1'b1;
        if (i_restart) begin
          w_state_nxt = HDR;
        end
      end
      ERR: begin
        o_load_err = 1'b1;
        if (i_restart) begin
          w_state_nxt = HDR;
        end
      end
      default: begin
        w_state_nxt = HDR;
      end
    endcase
  end

  // Header capture, word counting and the registered imem write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hdr_idx    <= 1'b0;
      r_hdr_lo     <= '0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
    end else begin
      r_imem_we <= w_word_valid;
      if (w_word_valid) begin
        r_imem_addr  <= r_word_idx[ADDR_W-1:0];
        r_imem_wdata <= w_word;
        r_word_idx   <= r_word_idx + 1'b1;
      end
      if (r_state == HDR) begin
        if (w_xfer) begin
          if (w_hdr_last) begin
            r_hdr_idx  <= 1'b0;
            r_count    <= w_hdr_n;
            r_word_idx <= '0;
          end else begin
            r_hdr_lo  <= i_rx_data;
            r_hdr_idx <= 1'b1;
          end
        end
      end else begin
        r_hdr_idx <= 1'b0;
      end
    end
  end

  assign o_rx_ready   = w_rx_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;

endmodule
